// File: rtl/kmeans_pkg.sv
// Shared types and constants for the k-means result drain.
package kmeans_pkg;

   localparam int K      = 4;
   localparam int ELEM_W = 39;
   localparam int IDX_W  = (K > 1) ? $clog2(K) : 1;

   typedef logic [ELEM_W-1:0] elem_t;
   typedef logic [IDX_W-1:0]  idx_t;

   // Record kind carried on out_kind
   localparam logic KIND_ELEM = 1'b0;
   localparam logic KIND_CENT = 1'b1;

   // One output record: what it is, its cluster/centroid index, and its value
   typedef struct packed {
      logic  kind;
      idx_t  tag;
      elem_t data;
   } record_t;

   localparam int REC_W = $bits(record_t);

   typedef enum logic {
      ST_STREAM = 1'b0,
      ST_DUMP   = 1'b1
   } state_t;

endpackage

// File: rtl/kmeans_sync_fifo.sv
// Single-clock FIFO with a combinational head view (first-word fall-through),
// so a record written at one edge is visible on the output the next cycle.
module kmeans_sync_fifo #(
   parameter int DEPTH = 8,
   parameter int WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head_data,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count_reg;
   logic             do_push;
   logic             do_pop;

   assign full      = (count_reg == FULL_CNT);
   assign empty     = (count_reg == '0);
   assign count     = count_reg;
   assign do_push   = push && !full;
   assign do_pop    = pop && !empty;
   assign head_data = mem[rd_ptr];

   // Storage write; contents are deliberately left unreset
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   // Pointer and occupancy tracking; pointers wrap naturally at a power-of-2 depth
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count_reg <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count_reg <= count_reg + (AW+1)'(1);
            2'b01:   count_reg <= count_reg - (AW+1)'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

endmodule

// File: rtl/kmeans_result_drain.sv
// Collects classified elements into a FIFO and streams them out; on request
// snapshots the centroids and emits them as a tagged burst on the same port.
module kmeans_result_drain
   import kmeans_pkg::*;
#(
   parameter int FIFO_DEPTH = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   input  logic [ELEM_W-1:0]   in_element,
   input  logic [IDX_W-1:0]    in_cluster,
   output logic                in_ready,
   input  logic [K*ELEM_W-1:0] centroids_in,
   input  logic                centroid_dump,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [ELEM_W-1:0]   out_data,
   output logic [IDX_W-1:0]    out_tag,
   output logic                out_kind,
   output logic                out_last,
   output logic                busy
);

   localparam idx_t LAST_IDX = idx_t'(K-1);

   state_t                      state;
   state_t                      state_next;
   logic                        pending;
   logic                        pending_next;
   idx_t                        index;
   idx_t                        index_next;
   logic                        snap_load;
   logic                        ready_en;
   logic [K*ELEM_W-1:0]         snap;
   elem_t                       snap_word [K];

   logic                        fifo_push;
   logic                        fifo_pop;
   record_t                     fifo_in;
   logic [REC_W-1:0]            fifo_head_bits;
   record_t                     fifo_head;
   logic                        fifo_full;
   logic                        fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   record_t                     out_rec;

   // View the snapshot as one word per centroid for the burst mux
   for (genvar gi = 0; gi < K; gi++) begin : g_snap_word
      assign snap_word[gi] = snap[gi*ELEM_W +: ELEM_W];
   end

   assign fifo_in   = '{kind: KIND_ELEM, tag: in_cluster, data: in_element};
   assign fifo_head = record_t'(fifo_head_bits);
   assign fifo_push = in_valid && in_ready;

   kmeans_sync_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (REC_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (fifo_push),
      .push_data (fifo_in),
      .pop       (fifo_pop),
      .head_data (fifo_head_bits),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   // State, pending flag, burst index and input-enable registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= ST_STREAM;
         pending  <= 1'b0;
         index    <= '0;
         ready_en <= 1'b0;
      end else begin
         state    <= state_next;
         pending  <= pending_next;
         index    <= index_next;
         ready_en <= 1'b1;
      end
   end

   // Centroid snapshot, frozen at the edge a dump request is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)         snap <= '0;
      else if (snap_load) snap <= centroids_in;
   end

   // Next-state logic and output mux; record fields stay zero while idle
   always_comb begin
      state_next   = state;
      pending_next = pending;
      index_next   = index;
      snap_load    = 1'b0;
      in_ready     = 1'b0;
      out_valid    = 1'b0;
      out_rec      = '0;
      fifo_pop     = 1'b0;
      case (state)
         ST_STREAM: begin
            in_ready  = ready_en && !fifo_full && !pending;
            out_valid = !fifo_empty;
            if (out_valid) out_rec = fifo_head;
            fifo_pop  = out_valid && out_ready;
            // Burst starts only once every element queued ahead of it has left
            if (pending && fifo_empty) begin
               state_next   = ST_DUMP;
               index_next   = '0;
               pending_next = 1'b0;
            end else if (centroid_dump && !pending) begin
               snap_load    = 1'b1;
               pending_next = 1'b1;
            end
         end
         ST_DUMP: begin
            out_valid = 1'b1;
            out_rec   = '{kind: KIND_CENT, tag: index, data: snap_word[index]};
            if (out_ready) begin
               if (index == LAST_IDX) begin
                  state_next = ST_STREAM;
                  index_next = '0;
               end else begin
                  index_next = index + idx_t'(1);
               end
            end
         end
         default: begin
            state_next = ST_STREAM;
         end
      endcase
   end

   assign out_data = out_rec.data;
   assign out_tag  = out_rec.tag;
   assign out_kind = out_rec.kind;
   assign out_last = (state == ST_DUMP) && (index == LAST_IDX);
   assign busy     = (fifo_count != '0) || pending || (state == ST_DUMP);

endmodule

// File: tb/tb_kmeans_result_drain.sv
// Randomised and directed bench for kmeans_result_drain with a queue-based
// reference model of the expected output record order.
module tb_kmeans_result_drain;
   import kmeans_pkg::*;

   localparam int DEPTH = 8;

   logic                clk = 1'b0;
   logic                reset = 1'b0;
   logic                in_valid = 1'b0;
   logic [ELEM_W-1:0]   in_element = '0;
   logic [IDX_W-1:0]    in_cluster = '0;
   logic [K*ELEM_W-1:0] centroids_in = '0;
   logic                centroid_dump = 1'b0;
   logic                out_ready = 1'b0;
   logic                in_ready;
   logic                out_valid;
   logic [ELEM_W-1:0]   out_data;
   logic [IDX_W-1:0]    out_tag;
   logic                out_kind;
   logic                out_last;
   logic                busy;

   int compared = 0;
   int mismatched = 0;

   // Reference model: expected records in emission order
   logic              m_kind [$];
   logic [IDX_W-1:0]  m_tag  [$];
   logic [ELEM_W-1:0] m_data [$];
   logic              m_ready_en = 1'b0;

   // Previous-cycle output view, for the hold-while-stalled rule
   logic              p_valid = 1'b0;
   logic              p_ready = 1'b0;
   logic [63:0]       p_rec = '0;

   int n_elem_out = 0;
   int n_cent_out = 0;

   kmeans_result_drain #(.FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .reset         (reset),
      .in_valid      (in_valid),
      .in_element    (in_element),
      .in_cluster    (in_cluster),
      .in_ready      (in_ready),
      .centroids_in  (centroids_in),
      .centroid_dump (centroid_dump),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_data      (out_data),
      .out_tag       (out_tag),
      .out_kind      (out_kind),
      .out_last      (out_last),
      .busy          (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic model_has_cent();
      for (int i = 0; i < m_kind.size(); i++)
         if (m_kind[i] == KIND_CENT) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [ELEM_W-1:0] rnd_elem();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[ELEM_W-1:0];
   endfunction

   function automatic logic [63:0] cur_rec();
      return 64'({out_data, out_tag, out_kind, out_last});
   endfunction

   // One clock: check outputs against the model, then advance model and DUT
   task automatic cycle();
      logic exp_rdy;
      logic pend;
      logic in_x;
      logic out_x;
      logic exp_last;
      #1;
      pend    = model_has_cent();
      exp_rdy = m_ready_en && !pend && (m_kind.size() < DEPTH);
      check("in_ready", 64'(in_ready), 64'(exp_rdy));
      check("busy", 64'(busy), 64'(m_kind.size() != 0));
      if (m_kind.size() == 0)
         check("out_valid_idle", 64'(out_valid), 64'(0));
      else if (m_kind[0] == KIND_ELEM)
         check("out_valid_elem", 64'(out_valid), 64'(1));
      if (!out_valid) check("out_zero", cur_rec(), 64'(0));
      if (p_valid && !p_ready) begin
         check("hold_valid", 64'(out_valid), 64'(1));
         check("hold_rec", cur_rec(), p_rec);
      end
      out_x = out_valid && out_ready;
      in_x  = in_valid && in_ready;
      if (out_x) begin
         if (m_kind.size() == 0) begin
            check("spurious_out", 64'(out_valid), 64'(0));
         end else begin
            exp_last = (m_kind[0] == KIND_CENT) && (m_tag[0] == IDX_W'(K-1));
            check("out_kind", 64'(out_kind), 64'(m_kind[0]));
            check("out_tag", 64'(out_tag), 64'(m_tag[0]));
            check("out_data", 64'(out_data), 64'(m_data[0]));
            check("out_last", 64'(out_last), 64'(exp_last));
            if (m_kind[0] == KIND_CENT) n_cent_out++; else n_elem_out++;
            void'(m_kind.pop_front());
            void'(m_tag.pop_front());
            void'(m_data.pop_front());
         end
      end
      if (in_x) begin
         m_kind.push_back(KIND_ELEM);
         m_tag.push_back(in_cluster);
         m_data.push_back(in_element);
      end
      if (centroid_dump && !pend) begin
         for (int i = 0; i < K; i++) begin
            m_kind.push_back(KIND_CENT);
            m_tag.push_back(IDX_W'(i));
            m_data.push_back(centroids_in[i*ELEM_W +: ELEM_W]);
         end
      end
      p_valid = out_valid;
      p_ready = out_ready;
      p_rec   = cur_rec();
      @(posedge clk);
      m_ready_en = 1'b1;
      @(negedge clk);
   endtask

   // Present one element until it is accepted, bounded
   task automatic offer(input logic [ELEM_W-1:0] e, input logic [IDX_W-1:0] c);
      logic done;
      done       = 1'b0;
      in_element = e;
      in_cluster = c;
      in_valid   = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         done = in_ready;
         cycle();
      end
      check("offer_timeout", 64'(done), 64'(1));
      in_valid = 1'b0;
   endtask

   // Accept everything until the model is empty, bounded
   task automatic drain();
      out_ready = 1'b1;
      for (int i = 0; i < 100 && m_kind.size() != 0; i++) cycle();
      check("drain_timeout", 64'(m_kind.size()), 64'(0));
      cycle();
      check("drain_busy", 64'(busy), 64'(0));
   endtask

   // Assert reset between edges and check the asynchronous clear
   task automatic async_reset();
      #2 reset = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(0));
      m_kind.delete();
      m_tag.delete();
      m_data.delete();
      m_ready_en = 1'b0;
      p_valid    = 1'b0;
      @(negedge clk);
      check("rst_hold_valid", 64'(out_valid), 64'(0));
      reset = 1'b1;
   endtask

   initial begin
      logic [ELEM_W-1:0] single_val;
      int cent_start;
      int elem_start;
      logic [ELEM_W-1:0] prev_in;

      // Reset held for two cycles with in_valid asserted
      in_valid = 1'b1;
      repeat (2) begin
         @(negedge clk);
         check("reset_out_valid", 64'(out_valid), 64'(0));
         check("reset_busy", 64'(busy), 64'(0));
         check("reset_in_ready", 64'(in_ready), 64'(0));
      end
      reset    = 1'b1;
      in_valid = 1'b0;
      cycle();
      check("post_reset_in_ready", 64'(in_ready), 64'(1));

      // Single element latency and clear-out
      single_val = 39'b100110100000110011000101010100110000100;
      out_ready  = 1'b1;
      offer(single_val, 2'd2);
      check("single_valid", 64'(out_valid), 64'(1));
      check("single_data", 64'(out_data), 64'(single_val));
      check("single_tag", 64'(out_tag), 64'(2));
      check("single_kind", 64'(out_kind), 64'(0));
      cycle();
      check("single_gone", 64'(out_valid), 64'(0));

      // Backpressure: 8 fill the FIFO, the 9th is held
      out_ready = 1'b0;
      elem_start = n_elem_out;
      for (int v = 1; v <= 8; v++) offer(ELEM_W'(v), IDX_W'(v));
      check("bp_full", 64'(in_ready), 64'(0));
      in_element = ELEM_W'(9);
      in_cluster = IDX_W'(1);
      in_valid   = 1'b1;
      repeat (2) cycle();
      out_ready = 1'b1;
      for (int i = 0; i < 20 && in_valid; i++) begin
         #1;
         if (in_ready) begin
            cycle();
            in_valid = 1'b0;
         end else begin
            cycle();
         end
      end
      in_valid = 1'b0;
      drain();
      check("bp_count", 64'(n_elem_out - elem_start), 64'(9));

      // Dump ordering: queued elements first, snapshot unaffected by later changes
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) offer(rnd_elem(), IDX_W'($urandom_range(0, K-1)));
      centroids_in  = {39'd40, 39'd30, 39'd20, 39'd10};
      centroid_dump = 1'b1;
      cent_start    = n_cent_out;
      cycle();
      centroid_dump = 1'b0;
      centroids_in  = '0;
      drain();
      check("dump_cent_count", 64'(n_cent_out - cent_start), 64'(K));

      // Dump under stall with ignored repeat requests
      for (int i = 0; i < K; i++) centroids_in[i*ELEM_W +: ELEM_W] = rnd_elem();
      centroid_dump = 1'b1;
      cent_start    = n_cent_out;
      cycle();
      in_element = rnd_elem();
      in_valid   = 1'b1;
      for (int i = 0; i < 40 && (n_cent_out - cent_start) < K; i++) begin
         out_ready     = i[0];
         centroid_dump = ($urandom_range(0, 2) == 0);
         cycle();
      end
      centroid_dump = 1'b0;
      in_valid      = 1'b0;
      drain();
      check("stall_cent_count", 64'(n_cent_out - cent_start), 64'(K));

      // Concurrent push and pop with one record in the FIFO
      out_ready = 1'b0;
      prev_in   = rnd_elem();
      offer(prev_in, 2'd1);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         in_element = rnd_elem();
         in_cluster = IDX_W'(i);
         #1;
         check("cc_data", 64'(out_data), 64'(prev_in));
         prev_in = in_element;
         cycle();
      end
      in_valid = 1'b0;
      drain();

      // Randomised traffic with occasional dumps
      for (int i = 0; i < 400; i++) begin
         in_valid      = $urandom_range(0, 1);
         in_element    = rnd_elem();
         in_cluster    = IDX_W'($urandom_range(0, K-1));
         out_ready     = ($urandom_range(0, 3) != 0);
         centroid_dump = ($urandom_range(0, 15) == 0);
         for (int c = 0; c < K; c++) centroids_in[c*ELEM_W +: ELEM_W] = rnd_elem();
         cycle();
      end
      in_valid      = 1'b0;
      centroid_dump = 1'b0;
      drain();

      // Reset with elements queued
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) offer(rnd_elem(), IDX_W'(i));
      async_reset();
      cycle();

      // Reset in the middle of a burst, then confirm nothing stale survives
      centroid_dump = 1'b1;
      cycle();
      centroid_dump = 1'b0;
      out_ready     = 1'b1;
      cycle();
      cycle();
      check("mid_dump_kind", 64'(out_kind), 64'(1));
      async_reset();
      cycle();
      offer(rnd_elem(), 2'd3);
      drain();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/kmeans_result_drain.md
Name: kmeans_result_drain

Overview:
Output-side collector for the k-means toplevel. It accepts classified elements (element plus assigned cluster index) from the datapath and buffers them in a small FIFO. It streams them to the host or downstream with a valid/ready handshake. On request it snapshots the K centroids and emits them as a tagged record burst, so the element input stream and the centroid readout leave the chip through a single output interface.

Parameters:
K, 4, number of clusters (the codebase `K value)
ELEM_W, 39, element/centroid word width (3 x 13-bit fields)
IDX_W, $clog2(K), cluster index width
FIFO_DEPTH, 8, element record buffer depth (power of 2, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
in_valid  in  1  classified element present
in_element  in  ELEM_W  element value
in_cluster  in  IDX_W  assigned cluster index
in_ready  out  1  drain can accept; transfer when in_valid && in_ready
centroids_in  in  K*ELEM_W  packed centroids, centroid i at bits [i*ELEM_W +: ELEM_W]
centroid_dump  in  1  single-cycle request to emit centroid burst
out_valid  out  1  record present
out_ready  in  1  downstream accepts; transfer when out_valid && out_ready
out_data  out  ELEM_W  element or centroid value
out_tag  out  IDX_W  cluster index / centroid index
out_kind  out  1  0 = element record, 1 = centroid record
out_last  out  1  high on final centroid record (index K-1) only
busy  out  1  FIFO non-empty, dump pending, or dump active

Behaviour:
- Reset (reset=0, async): FIFO count/pointers=0, state=STREAM, pending=0, dump index=0. out_valid=0, out_last=0, busy=0, in_ready=0 while reset is held, 1 from the first edge after release. FIFO storage is not reset.
- out_data/out_tag/out_kind/out_last are forced to 0 whenever out_valid=0.
- States: STREAM, DUMP.
- STREAM: in_ready = (count != FIFO_DEPTH) && !pending. out_valid = (count != 0). Outputs present the FIFO head.
- Latency: an element accepted at edge N into an empty FIFO gives out_valid high after edge N (visible cycle N+1).
- Simultaneous push and pop: count unchanged. Push is blocked when full (in_ready=0), so there is no push-when-full.
- Once out_valid is high, all out_* are held stable until the out_ready transfer.
- centroid_dump sampled high in STREAM with pending=0: the centroids_in snapshot is registered at that edge and pending=1. An element accepted in the same cycle is queued ahead of the burst. Later centroids_in changes have no effect.
- STREAM with pending=1 and count=0: go to DUMP, index=0, pending=0.
- DUMP: in_ready=0, out_valid=1, out_data=snapshot[index], out_tag=index, out_kind=1, out_last=(index==K-1). Index increments on each transfer. Transfer at index K-1 returns to STREAM.
- centroid_dump while pending=1 or in DUMP: ignored (no queueing, no restart).
- reset asserted mid-stream or mid-dump: the burst is aborted immediately, and buffered elements and the snapshot are discarded.
- busy = (count != 0) || pending || (state == DUMP).

Decomposition:
- Shared package kmeans_pkg: K, ELEM_W, IDX_W, typedef elem_t (logic [ELEM_W-1:0]), typedef idx_t, record kind constants KIND_ELEM=0 and KIND_CENT=1, and a packed record struct {kind, tag, data}.
- Sub-module kmeans_sync_fifo: parameterised single-clock FIFO (push/pop/full/empty/count, async active-low reset) holding records. The FSM, snapshot register and output mux live in kmeans_result_drain.

Test Plan:
- Reset: hold reset=0 for 2 cycles with in_valid=1 -> out_valid=0, busy=0, in_ready=0; after release in_ready=1. Assert reset with 3 elements queued -> out_valid drops to 0 asynchronously and count=0.
- Single element: in_element=39'b100110100000110011000101010100110000100, in_cluster=2, out_ready=1, accepted at edge N -> cycle N+1 shows out_valid=1, out_data=that value, out_tag=2, out_kind=0; cycle N+2 shows out_valid=0.
- Backpressure: out_ready=0, offer 9 elements with values 1..9 -> in_ready=0 after the 8th acceptance and the 9th is held. Then out_ready=1 -> outputs 1..8 in order, the 9th is accepted, and nothing is lost or duplicated.
- Dump ordering: centroids 39'd10,20,30,40, 3 elements queued, centroid_dump pulse, then centroids_in changed to 0 -> 3 kind=0 records, then kind=1 records with tags 0..3 and data 10,20,30,40, out_last=1 only on tag 3.
- Dump under stall: out_ready toggles every cycle during DUMP -> each centroid appears exactly once and is held stable while out_ready=0. centroid_dump pulses during DUMP are ignored (exactly 4 centroid records). in_ready=0 throughout.
- Concurrent push/pop: count=1, in_valid=1 and out_ready=1 for 5 cycles -> count stays 1 and outputs follow input order with a one-record lag.
